rom_sdram_writer: RTL and testbench
===================================

// Module: rom_sdram_writer
// PURPOSE
//  Consumes the byte stream produced by the menu/SD loader (dout/dout_valid/loading) and writes it to
//  SDRAM as 16-bit little-endian words, starting at BASE_ADDR. Buffers bursts in a small FIFO so the loader
//  never stalls while the SDRAM port is busy with refresh or other clients. Reports completion/overflow to the top.
// PARAMETERS
//  BASE_ADDR   22'h0  SDRAM word address of ROM byte 0
//  FIFO_DEPTH  8      word FIFO entries (power of 2, >=2)
// PORTS
//  wclk          in   1   system clock (same domain as loader)
//  reset         in   1   asynchronous, active-high reset
//  loading       in   1   loader busy; rising edge = new image, falling edge = end of image
//  din           in   8   ROM byte (loader dout)
//  din_valid     in   1   1-cycle strobe, din valid
//  mem_req       out  1   write request, held high until mem_ack
//  mem_addr      out  22  SDRAM word address
//  mem_din       out  16  write data {odd byte, even byte}
//  mem_ds        out  2   byte enables: [0]=low/even byte, [1]=high/odd byte
//  mem_ack       in   1   1-cycle strobe: current write accepted
//  byte_count    out  24  bytes accepted this image
//  busy          out  1   pair reg, FIFO or engine non-empty
//  done          out  1   1-cycle pulse: image fully written
//  overflow      out  1   sticky: a word was dropped on full FIFO
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; pair reg empty; engine IDLE; done not armed.
//  Image start (loading 0->1, detected via registered copy): byte_count<=0, pair reg cleared, FIFO flushed,
//   overflow<=0, done disarmed. An in-flight request is NOT dropped: mem_req/addr/data stay until mem_ack.
//  Pairing: byte_count[0]==0 -> din latched as low byte; ==1 -> word {din, low} pushed with ds=2'b11,
//   addr = BASE_ADDR + byte_count[23:1]. byte_count increments on every din_valid while loading (wraps at 2^24).
//  din_valid while loading==0 ignored.
//  Image end (loading 1->0): if pair reg holds an odd-count leftover byte, push {8'h00, low} with ds=2'b01
//   same cycle; arm done.
//  Push on full FIFO: word discarded, overflow<=1 (sticky until next image start); byte_count still advances.
//  Simultaneous push and pop on full FIFO: pop frees slot, push succeeds (no overflow).
//  Write engine FSM:
//   IDLE: FIFO non-empty -> load head into mem_addr/din/ds, pop, mem_req<=1, -> REQ (1 cycle FIFO-to-req).
//   REQ : hold outputs; on mem_ack -> mem_req<=0; next cycle back to IDLE. mem_ack in IDLE ignored.
//   Back-to-back: one idle cycle minimum between requests (req deasserts for >=1 cycle after ack).
//  done: pulse 1 cycle when armed && !loading && FIFO empty && pair empty && engine IDLE && !mem_req; disarms.
//   Loading re-rise before done fires disarms (no done for aborted image).
//  busy = pair reg full | FIFO non-empty | engine in REQ.
//  Reset asserted mid-write: mem_req drops immediately (async), all state cleared; no done.
// TESTING
//  1) loading rise, bytes 11,22,33,44 one/cycle, mem_ack 2 cycles after each req -> writes
//     addr BASE+0 data 2211 ds 11, addr BASE+1 data 4433 ds 11; loading fall -> done pulse once, byte_count=4.
//  2) 3 bytes AA,BB,CC then loading fall -> 2nd write data 00CC ds 01 at BASE+1; done after its ack.
//  3) mem_ack held low 40 cycles, 20 bytes streamed with FIFO_DEPTH=8 -> overflow=1, exactly 8 words
//     buffered plus 1 in-flight written in order; next loading rise clears overflow.
//  4) loading re-rises while req in flight -> req held until ack, FIFO flushed, new image writes BASE+0.
//  5) reset pulsed during REQ -> mem_req=0 same cycle, byte_count=0, busy=0, no done pulse.
//  6) din_valid pulses with loading=0 -> no mem_req, byte_count unchanged.

Source files
------------

// File: rtl/rom_sdram_writer.sv
// Packs the loader byte stream into 16-bit little-endian SDRAM writes.
// A small word FIFO decouples the loader from SDRAM port stalls.
module rom_sdram_writer #(
    parameter logic [21:0] BASE_ADDR  = 22'h0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wclk,
    input  logic        reset,
    input  logic        loading,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_ds,
    input  logic        mem_ack,
    output logic [23:0] byte_count,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t      r_state;
    logic [39:0] r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_loading_d;
    logic [7:0]  r_low;
    logic        r_pair_full;
    logic [23:0] r_byte_count;
    logic        r_overflow;
    logic        r_armed;
    logic        r_done;
    logic        r_mem_req;
    logic [21:0] r_mem_addr;
    logic [15:0] r_mem_din;
    logic [1:0]  r_mem_ds;

    logic        w_rise, w_fall, w_take;
    logic [23:0] w_cnt_base;
    logic [21:0] w_addr;
    logic        w_push_pair, w_push_left, w_push, w_push_ok, w_pop;
    logic        w_empty, w_full, w_done_cond;
    logic [39:0] w_push_word, w_head;

    assign w_rise      = loading & ~r_loading_d;
    assign w_fall      = ~loading & r_loading_d;
    assign w_take      = loading & din_valid;
    // A byte arriving on the image-start cycle belongs to the new image.
    assign w_cnt_base  = w_rise ? 24'd0 : r_byte_count;
    assign w_addr      = BASE_ADDR + w_cnt_base[22:1];
    assign w_push_pair = w_take & w_cnt_base[0];
    assign w_push_left = w_fall & r_pair_full;
    assign w_push      = w_push_pair | w_push_left;
    assign w_push_word = w_push_pair ? {w_addr, din, r_low, 2'b11}
                                     : {w_addr, 8'h00, r_low, 2'b01};

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A flush on image start must not hand stale words to the engine.
    assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~w_rise;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_head    = r_fifo[r_rd_ptr[AW-1:0]];

    assign w_done_cond = r_armed & ~loading & w_empty & ~r_pair_full &
                         (r_state == S_IDLE) & ~r_mem_req;

    always_ff @(posedge wclk) begin
        if (w_push_ok)
            r_fifo[r_wr_ptr[AW-1:0]] <= w_push_word;
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            r_loading_d  <= 1'b0;
            r_low        <= 8'h00;
            r_pair_full  <= 1'b0;
            r_byte_count <= 24'd0;
            r_overflow   <= 1'b0;
            r_armed      <= 1'b0;
            r_done       <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_loading_d <= loading;
            r_done      <= w_done_cond;

            if (w_take) begin
                r_byte_count <= w_cnt_base + 24'd1;
                if (!w_cnt_base[0]) begin
                    r_low       <= din;
                    r_pair_full <= 1'b1;
                end else begin
                    r_pair_full <= 1'b0;
                end
            end else if (w_rise) begin
                r_byte_count <= 24'd0;
                r_pair_full  <= 1'b0;
            end else if (w_fall) begin
                r_pair_full <= 1'b0;
            end

            if (w_rise)
                r_overflow <= 1'b0;
            else if (w_push & ~w_push_ok)
                r_overflow <= 1'b1;

            if (w_rise)
                r_armed <= 1'b0;
            else if (w_fall)
                r_armed <= 1'b1;
            else if (w_done_cond)
                r_armed <= 1'b0;

            if (w_rise) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Write engine; an in-flight request survives image restarts.
    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 22'd0;
            r_mem_din  <= 16'd0;
            r_mem_ds   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_mem_addr <= w_head[39:18];
                        r_mem_din  <= w_head[17:2];
                        r_mem_ds   <= w_head[1:0];
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign mem_ds     = r_mem_ds;
    assign byte_count = r_byte_count;
    assign overflow   = r_overflow;
    assign done       = r_done;
    assign busy       = r_pair_full | ~w_empty | (r_state == S_REQ);
endmodule

// File: tb/tb_rom_sdram_writer.sv
// Directed bench for rom_sdram_writer: expected writes queued as bytes are driven,
// checked against the DUT when the modelled SDRAM port acknowledges them.
module tb_rom_sdram_writer;
    localparam logic [21:0] BASE = 22'h001000;

    logic        wclk = 1'b0;
    logic        reset, loading, din_valid, mem_ack;
    logic [7:0]  din;
    logic        mem_req, busy, done, overflow;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_ds;
    logic [23:0] byte_count;

    rom_sdram_writer #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .wclk(wclk), .reset(reset), .loading(loading), .din(din), .din_valid(din_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ds(mem_ds),
        .mem_ack(mem_ack), .byte_count(byte_count), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    int          n_cmp = 0, n_err = 0;
    logic [39:0] sb [$];
    bit          ack_en = 1'b1;
    int          ack_delay = 2;
    int          done_cnt = 0, req_cnt = 0;
    logic [23:0] m_cnt = 0;
    logic [7:0]  m_low = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] ent(input logic [21:0] a, input logic [15:0] d, input logic [1:0] ds);
        return {a, d, ds};
    endfunction

    // SDRAM port model: acks ack_delay cycles after req, checks each accepted write
    initial begin
        int wcnt = 0;
        logic [39:0] e;
        logic        prev_req = 1'b0;
        mem_ack = 1'b0;
        forever begin
            @(negedge wclk);
            if (done) begin
                done_cnt++;
                check("done_after_drain", {31'd0, sb.size() == 0, mem_req}, 64'h2);
            end
            if (mem_req && !prev_req) req_cnt++;
            prev_req = mem_req;
            if (mem_ack) begin
                check("req_gap_after_ack", mem_req, 0);
                mem_ack = 1'b0;
            end else if (mem_req && ack_en) begin
                wcnt++;
                if (wcnt >= ack_delay) begin
                    wcnt = 0;
                    check("sb_nonempty_on_write", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("write_addr_data_ds", {mem_addr, mem_din, mem_ds}, e);
                    end
                    mem_ack = 1'b1;
                end
            end else if (!mem_req) begin
                wcnt = 0;
            end
        end
    end

    task automatic start_image();
        loading = 1'b1;
        m_cnt = 0;
        @(negedge wclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_push);
        din = b;
        din_valid = 1'b1;
        if (loading) begin
            if (m_cnt[0]) begin
                if (exp_push) sb.push_back(ent(BASE + m_cnt[22:1], {b, m_low}, 2'b11));
            end else begin
                m_low = b;
            end
            m_cnt++;
        end
        @(negedge wclk);
        din_valid = 1'b0;
    endtask

    task automatic end_image();
        if (m_cnt[0]) sb.push_back(ent(BASE + m_cnt[22:1], {8'h00, m_low}, 2'b01));
        loading = 1'b0;
        @(negedge wclk);
    endtask

    task automatic wait_quiet(input string tag, input int max_cycles);
        bit ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy && !mem_req && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge wclk);
        end
        check(tag, ok, 1);
        repeat (4) @(negedge wclk);
    endtask

    initial begin
        bit          got;
        logic [23:0] bc;
        int          rc;
        reset = 1'b1; loading = 1'b0; din = 8'h00; din_valid = 1'b0;
        repeat (3) @(negedge wclk);
        check("rst_outputs", {mem_req, busy, done, overflow, byte_count}, 64'h0);
        check("rst_mem_bus", {mem_addr, mem_din, mem_ds}, 64'h0);
        reset = 1'b0;
        @(negedge wclk);

        // 1) four bytes, two full words
        done_cnt = 0;
        start_image();
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
        end_image();
        wait_quiet("t1_quiet", 200);
        check("t1_done_once", done_cnt, 1);
        check("t1_byte_count", byte_count, 24'd4);
        check("t1_overflow", overflow, 0);

        // 2) odd byte count leaves a half word
        done_cnt = 0;
        start_image();
        send_byte(8'hAA, 1); send_byte(8'hBB, 1); send_byte(8'hCC, 1);
        end_image();
        wait_quiet("t2_quiet", 200);
        check("t2_done_once", done_cnt, 1);
        check("t2_byte_count", byte_count, 24'd3);

        // 3) stalled port: 1 in flight + 8 buffered, 10th word dropped
        done_cnt = 0;
        ack_en = 1'b0;
        start_image();
        for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i), i < 18);
        check("t3_overflow_set", overflow, 1);
        check("t3_req_held", {busy, mem_req}, 2'b11);
        check("t3_byte_count", byte_count, 24'd20);
        repeat (20) @(negedge wclk);
        ack_en = 1'b1;
        end_image();
        wait_quiet("t3_quiet", 400);
        check("t3_done_once", done_cnt, 1);
        check("t3_overflow_sticky", overflow, 1);
        start_image();
        check("t3_overflow_cleared", overflow, 0);
        end_image();
        wait_quiet("t3b_quiet", 50);
        check("t3_empty_image_done", done_cnt, 2);

        // 4) restart while a write is in flight
        done_cnt = 0;
        ack_en = 1'b0;
        start_image();
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 0); send_byte(8'h04, 0);
        @(negedge wclk);
        loading = 1'b0;
        @(negedge wclk);
        start_image();
        check("t4_req_kept", mem_req, 1);
        check("t4_count_reset", byte_count, 24'd0);
        send_byte(8'h5A, 1); send_byte(8'hA5, 1);
        ack_en = 1'b1;
        end_image();
        wait_quiet("t4_quiet", 200);
        check("t4_done_once", done_cnt, 1);

        // 5) reset during an outstanding request
        done_cnt = 0;
        ack_en = 1'b0;
        start_image();
        send_byte(8'hDE, 0); send_byte(8'hAD, 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (mem_req) got = 1'b1;
            else @(negedge wclk);
        end
        check("t5_req_seen", got, 1);
        reset = 1'b1;
        loading = 1'b0;
        #1;
        check("t5_req_async_drop", mem_req, 0);
        check("t5_state_cleared", {busy, byte_count}, 64'h0);
        @(negedge wclk);
        reset = 1'b0;
        ack_en = 1'b1;
        repeat (10) @(negedge wclk);
        check("t5_no_done", done_cnt, 0);
        check("t5_no_req", mem_req, 0);

        // 6) strobes outside an image are ignored
        bc = byte_count;
        rc = req_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'hF0 + 8'(i), 0);
        repeat (5) @(negedge wclk);
        check("t6_count_unchanged", byte_count, bc);
        check("t6_no_req", req_cnt, rc);
        check("t6_idle", busy, 0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
